// File: rtl/modulo_logico_acc.sv
// Registered bitwise logic unit (XOR/AND/OR/XNOR) with a multi-beat XOR-accumulate
// mode and valid/ready handshakes on both sides.
module modulo_logico_acc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             parity
);

  localparam logic [1:0]       OP_XOR  = 2'b00;
  localparam logic [1:0]       OP_AND  = 2'b01;
  localparam logic [1:0]       OP_OR   = 2'b10;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] acc;

  logic             beat;
  logic             last;
  logic [1:0]       op_sel;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] res;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_XOR:  r = x ^ y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      default: r = ~(x ^ y);
    endcase
    return r;
  endfunction

  // Per-beat datapath: op is taken live on the first beat, latched afterwards
  always_comb begin
    beat    = in_valid && in_ready;
    op_sel  = (state == S_ACC) ? op_q : op;
    len_eff = (len == '0) ? LEN_ONE : len;
    cnt_inc = cnt + LEN_ONE;
    f       = logic_op(op_sel, a, b);
    res     = (state == S_ACC) ? (acc ^ f) : f;
    last    = 1'b0;
    if (state == S_IDLE) begin
      last = !mode || (len_eff == LEN_ONE);
    end else if (state == S_ACC) begin
      last = (cnt_inc == len_q);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (beat) begin
          state_nxt = last ? S_OUT : S_ACC;
        end
      end
      S_ACC: begin
        if (beat && last) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_ACC:   in_ready  = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Accumulator, beat counter, latched controls and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      len_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      z      <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else if (beat) begin
      if (state == S_IDLE) begin
        op_q  <= op;
        len_q <= len_eff;
      end
      if (last) begin
        z      <= res;
        zero   <= (res == '0);
        parity <= ^res;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        acc <= res;
        cnt <= (state == S_IDLE) ? LEN_ONE : cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_modulo_logico_acc.sv
// Self-checking bench for modulo_logico_acc: directed steps plus randomized
// accumulate transactions against a queue-free fold-XOR reference model.
module tb_modulo_logico_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic       mode;
  logic [3:0] len;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] z;
  logic       zero;
  logic       parity;

  logic       iv8;
  logic       ir8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [1:0] op8;
  logic       mode8;
  logic [3:0] len8;
  logic       ov8;
  logic       or8;
  logic [7:0] z8;
  logic       zero8;
  logic       par8;

  int passed;
  int total;

  logic [3:0] beat_a [16];
  logic [3:0] beat_b [16];
  logic [1:0] beat_op[16];

  modulo_logico_acc #(.WIDTH(4), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode), .len(len),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero(zero), .parity(parity)
  );

  modulo_logico_acc #(.WIDTH(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .op(op8), .mode(mode8), .len(len8),
    .out_valid(ov8), .out_ready(or8),
    .z(z8), .zero(zero8), .parity(par8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_f(input logic [1:0] o, input logic [3:0] x,
                                       input logic [3:0] y);
    case (o)
      2'b00:   return x ^ y;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return ~(x ^ y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] e);
    chk({tag, "_valid"},  32'(out_valid), 32'd1);
    chk({tag, "_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_z"},      32'(z),         32'(e));
    chk({tag, "_zero"},   32'(zero),      32'(e == 4'd0));
    chk({tag, "_parity"}, 32'(parity),    32'(^e));
  endtask

  task automatic single(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] e;
    e         = ref_f(o, x, y);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    op        = o;
    mode      = 1'b0;
    len       = 4'($urandom);
    out_ready = 1'b1;
    chk("single_idle_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
    op       = 2'($urandom);
    check_out("single", e);
    @(negedge clk);
    chk("single_consumed_valid", 32'(out_valid), 32'd0);
    chk("single_consumed_ready", 32'(in_ready),  32'd1);
  endtask

  // One accumulate transaction using beat_* arrays; later beats carry junk controls
  task automatic acc_run(input logic [3:0] l, input int gap_min, input int gap_max,
                         input int hold);
    int         n;
    logic [3:0] e;
    n = (l == 4'd0) ? 1 : int'(l);
    e = 4'd0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gap_max, gap_min)) begin
          out_ready = 1'($urandom);
          chk("acc_gap_valid", 32'(out_valid), 32'd0);
          chk("acc_gap_ready", 32'(in_ready),  32'd1);
          @(negedge clk);
        end
      end
      in_valid  = 1'b1;
      a         = beat_a[i];
      b         = beat_b[i];
      op        = beat_op[i];
      mode      = (i == 0) ? 1'b1 : 1'($urandom);
      len       = (i == 0) ? l : 4'($urandom);
      out_ready = (i == n - 1) ? (hold == 0) : 1'($urandom);
      e         = e ^ ref_f(beat_op[0], beat_a[i], beat_b[i]);
      chk("acc_beat_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < n - 1) chk("acc_early_valid", 32'(out_valid), 32'd0);
    end
    check_out("acc", e);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      mode     = 1'b0;
      a        = 4'($urandom);
      b        = 4'($urandom);
      @(negedge clk);
      check_out("hold", e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("acc_consumed_valid", 32'(out_valid), 32'd0);
    chk("acc_consumed_ready", 32'(in_ready),  32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 4'h3;
    b         = 4'h1;
    op        = 2'b00;
    mode      = 1'b0;
    len       = 4'd0;
    out_ready = 1'b0;
    iv8       = 1'b0;
    a8        = 8'h00;
    b8        = 8'h00;
    op8       = 2'b00;
    mode8     = 1'b0;
    len8      = 4'd0;
    or8       = 1'b1;

    // Reset values, with a beat offered during reset
    repeat (2) @(negedge clk);
    chk("rst_z",      32'(z),         32'd0);
    chk("rst_zero",   32'(zero),      32'd1);
    chk("rst_parity", 32'(parity),    32'd0);
    chk("rst_valid",  32'(out_valid), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready),  32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // Directed XOR example, then exhaustive single-shot
    single(2'b00, 4'hA, 4'h5);
    chk("xor_a5_z", 32'(z), 32'hF);
    for (int o = 0; o < 4; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          single(2'(o), 4'(x), 4'(y));

    // Accumulate XOR, len=3, one idle cycle between beats
    beat_a[0] = 4'h1; beat_b[0] = 4'h0; beat_op[0] = 2'b00;
    beat_a[1] = 4'h2; beat_b[1] = 4'h0; beat_op[1] = 2'b00;
    beat_a[2] = 4'h4; beat_b[2] = 4'h0; beat_op[2] = 2'b00;
    acc_run(4'd3, 1, 1, 0);
    chk("acc3_z",      32'(z),      32'h7);
    chk("acc3_parity", 32'(parity), 32'd1);

    // AND latched on first beat; OR offered on later beat is ignored
    beat_a[0] = 4'hF; beat_b[0] = 4'h3; beat_op[0] = 2'b01;
    beat_a[1] = 4'hC; beat_b[1] = 4'h4; beat_op[1] = 2'b10;
    acc_run(4'd2, 0, 0, 0);
    chk("op_latched_z", 32'(z), 32'h7);

    // len=0 completes after one beat; backpressure held 5 cycles
    beat_a[0] = 4'h9; beat_b[0] = 4'h3; beat_op[0] = 2'b00;
    acc_run(4'd0, 0, 0, 5);
    chk("len0_z", 32'(z), 32'hA);

    // Reset in the middle of a 4-beat accumulation
    in_valid = 1'b1; a = 4'h5; b = 4'h0; op = 2'b00; mode = 1'b1; len = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 4'h6; b = 4'h0;
    @(negedge clk);
    chk("midacc_valid", 32'(out_valid), 32'd0);
    rst = 1'b1; in_valid = 1'b1; mode = 1'b0; a = 4'h6; b = 4'h3;
    @(negedge clk);
    chk("midrst_z",      32'(z),         32'd0);
    chk("midrst_zero",   32'(zero),      32'd1);
    chk("midrst_parity", 32'(parity),    32'd0);
    chk("midrst_valid",  32'(out_valid), 32'd0);
    chk("midrst_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", 32'(out_valid), 32'd0);
    chk("after_rst_z",     32'(z),         32'd0);
    single(2'b00, 4'h6, 4'h3);
    chk("fresh_xor_z", 32'(z), 32'h5);

    // Randomized accumulate transactions
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) begin
        beat_a[i]  = 4'($urandom);
        beat_b[i]  = 4'($urandom);
        beat_op[i] = 2'($urandom);
      end
      acc_run(4'($urandom), 0, 2, int'($urandom_range(3, 0)));
    end

    // WIDTH=8 instance
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0E; op8 = 2'b00; mode8 = 1'b0;
    chk("w8_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    iv8 = 1'b0;
    chk("w8_xor_valid",  32'(ov8),   32'd1);
    chk("w8_xor_z",      32'(z8),    32'hFE);
    chk("w8_xor_zero",   32'(zero8), 32'd0);
    chk("w8_xor_parity", 32'(par8),  32'd1);
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; op8 = 2'b11;
    @(negedge clk);
    iv8 = 1'b0;
    chk("w8_xnor_valid",  32'(ov8),   32'd1);
    chk("w8_xnor_z",      32'(z8),    32'h00);
    chk("w8_xnor_zero",   32'(zero8), 32'd1);
    chk("w8_xnor_parity", 32'(par8),  32'd0);
    @(negedge clk);
    chk("w8_consumed", 32'(ov8), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
